// File: rtl/fetch_ctrl.sv
// Fetch controller: issues one instruction-memory read per instruction, waits
// for the acknowledge or a timeout, and presents the result to IF/ID.
// A CP0 redirect cancels whatever is in flight. An outstanding read is drained
// so that its late acknowledge never reaches IF/ID.
module fetch_ctrl #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [4:0]  pc_exc,
    input  logic        redirect,
    input  logic        hold,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic        valid,
    output logic [31:0] code,
    output logic [4:0]  exc,
    output logic        stallPC,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {StIdle, StWait, StFull, StDrain} state_e;

    localparam logic [7:0] LastWait = 8'(MAX_WAIT - 1);
    localparam logic [4:0] ExcIbe   = 5'd6;  // instruction bus error

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] code_q, code_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic        req_c, valid_c, stall_c;
    logic        wait_last;

    assign wait_last = (wait_cnt_q == LastWait);

    // Next-state and output decode; redirect outranks every other event.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        code_d      = code_q;
        exc_d       = exc_q;
        fetch_cnt_d = fetch_cnt_q;
        req_c       = 1'b0;
        valid_c     = 1'b0;
        stall_c     = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (redirect) begin
                    stall_c = 1'b0;
                end else if (pc_exc != 5'd0) begin
                    code_d  = 32'd0;
                    exc_d   = pc_exc;
                    state_d = StFull;
                end else begin
                    req_c      = 1'b1;
                    wait_cnt_d = 8'd0;
                    state_d    = StWait;
                end
            end
            StWait: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (redirect) begin
                    stall_c = 1'b0;
                    state_d = StDrain;
                end else if (im_ack) begin
                    code_d  = im_rdata;
                    exc_d   = 5'd0;
                    state_d = StFull;
                end else if (wait_last) begin
                    code_d  = 32'd0;
                    exc_d   = ExcIbe;
                    state_d = StFull;
                end
            end
            StFull: begin
                if (redirect) begin
                    stall_c = 1'b0;
                    state_d = StIdle;
                end else begin
                    valid_c = 1'b1;
                    if (!hold) begin
                        stall_c     = 1'b0;
                        fetch_cnt_d = fetch_cnt_q + 32'd1;
                        state_d     = StIdle;
                    end
                end
            end
            StDrain: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (redirect) begin
                    stall_c = 1'b0;
                end else if (im_ack || wait_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and buffer registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            wait_cnt_q  <= 8'd0;
            code_q      <= 32'd0;
            exc_q       <= 5'd0;
            fetch_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            code_q      <= code_d;
            exc_q       <= exc_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    // Outputs are masked by reset so they take reset values without a clock.
    assign im_req    = reset & req_c;
    assign im_addr   = im_req ? pc : 32'd0;
    assign valid     = reset & valid_c;
    assign stallPC   = ~reset | stall_c;
    assign code      = code_q;
    assign exc       = exc_q;
    assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl: one record per clock cycle.
module tb_fetch_ctrl;

    typedef struct {
        string       name;
        logic        rst;
        logic [31:0] pc;
        logic [4:0]  pc_exc;
        logic        redirect;
        logic        hold;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_code;
        logic [4:0]  e_exc;
        logic        e_stall;
        logic [31:0] e_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc = 32'd0;
    logic [4:0]  pc_exc = 5'd0;
    logic        redirect = 1'b0;
    logic        hold = 1'b0;
    logic        im_ack = 1'b0;
    logic [31:0] im_rdata = 32'd0;
    logic        im_req, valid, stallPC;
    logic [31:0] im_addr, code, fetch_cnt;
    logic [4:0]  exc;

    int n_vec = 0;
    int n_err = 0;

    fetch_ctrl #(.MAX_WAIT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .pc_exc    (pc_exc),
        .redirect  (redirect),
        .hold      (hold),
        .im_req    (im_req),
        .im_addr   (im_addr),
        .im_ack    (im_ack),
        .im_rdata  (im_rdata),
        .valid     (valid),
        .code      (code),
        .exc       (exc),
        .stallPC   (stallPC),
        .fetch_cnt (fetch_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(string nm, logic r, logic [31:0] p, logic [4:0] px,
                               logic rd, logic h, logic a, logic [31:0] d,
                               logic q, logic [31:0] ad, logic vl, logic [31:0] c,
                               logic [4:0] x, logic s, logic [31:0] n);
        vec_t t;
        t.name = nm; t.rst = r; t.pc = p; t.pc_exc = px; t.redirect = rd;
        t.hold = h; t.ack = a; t.rdata = d; t.e_req = q; t.e_addr = ad;
        t.e_valid = vl; t.e_code = c; t.e_exc = x; t.e_stall = s; t.e_cnt = n;
        return t;
    endfunction

    // Drive on the falling edge, compare 2 time units later (before the rising edge).
    task automatic apply(input vec_t t);
        @(negedge clk);
        reset = t.rst; pc = t.pc; pc_exc = t.pc_exc; redirect = t.redirect;
        hold = t.hold; im_ack = t.ack; im_rdata = t.rdata;
        #2;
        n_vec++;
        if (im_req !== t.e_req || im_addr !== t.e_addr || valid !== t.e_valid ||
            code !== t.e_code || exc !== t.e_exc || stallPC !== t.e_stall ||
            fetch_cnt !== t.e_cnt) begin
            n_err++;
            $display("FAIL %s: got req=%b addr=%h valid=%b code=%h exc=%0d stall=%b cnt=%0d ; want req=%b addr=%h valid=%b code=%h exc=%0d stall=%b cnt=%0d",
                     t.name, im_req, im_addr, valid, code, exc, stallPC, fetch_cnt,
                     t.e_req, t.e_addr, t.e_valid, t.e_code, t.e_exc, t.e_stall, t.e_cnt);
        end
    endtask

    vec_t tbl[27];

    initial begin
        //          name          rst pc           px rd h a rdata         req addr         vl code         x s cnt
        tbl[0]  = v("reset",        0, 32'h3000, 0, 0, 0, 0, 32'h0,        0, 32'h0,    0, 32'h0,        0, 1, 0);
        tbl[1]  = v("first_req",    1, 32'h3000, 0, 0, 0, 0, 32'h0,        1, 32'h3000, 0, 32'h0,        0, 1, 0);
        tbl[2]  = v("wait_ack",     1, 32'h3000, 0, 0, 0, 1, 32'h24080001, 0, 32'h0,    0, 32'h0,        0, 1, 0);
        tbl[3]  = v("full_out",     1, 32'h3000, 0, 0, 0, 0, 32'h0,        0, 32'h0,    1, 32'h24080001, 0, 0, 0);
        tbl[4]  = v("idle_ign_ack", 1, 32'h3004, 0, 0, 0, 1, 32'hBAD0BAD0, 1, 32'h3004, 0, 32'h24080001, 0, 1, 1);
        tbl[5]  = v("wait_ack2",    1, 32'h3004, 0, 0, 0, 1, 32'h8C090004, 0, 32'h0,    0, 32'h24080001, 0, 1, 1);
        tbl[6]  = v("hold1",        1, 32'h3004, 0, 0, 1, 0, 32'h0,        0, 32'h0,    1, 32'h8C090004, 0, 1, 1);
        tbl[7]  = v("hold2",        1, 32'h3004, 0, 0, 1, 1, 32'h0,        0, 32'h0,    1, 32'h8C090004, 0, 1, 1);
        tbl[8]  = v("hold3",        1, 32'h3004, 0, 0, 1, 0, 32'h0,        0, 32'h0,    1, 32'h8C090004, 0, 1, 1);
        tbl[9]  = v("hold4",        1, 32'h3004, 0, 0, 1, 0, 32'h0,        0, 32'h0,    1, 32'h8C090004, 0, 1, 1);
        tbl[10] = v("hold_release", 1, 32'h3004, 0, 0, 0, 0, 32'h0,        0, 32'h0,    1, 32'h8C090004, 0, 0, 1);
        tbl[11] = v("pc_exc_idle",  1, 32'h3002, 4, 0, 0, 0, 32'h0,        0, 32'h0,    0, 32'h8C090004, 0, 1, 2);
        tbl[12] = v("pc_exc_full",  1, 32'h3002, 4, 0, 0, 0, 32'h0,        0, 32'h0,    1, 32'h0,        4, 0, 2);
        tbl[13] = v("req3",         1, 32'h3008, 0, 0, 0, 0, 32'h0,        1, 32'h3008, 0, 32'h0,        4, 1, 3);
        tbl[14] = v("wait_noack",   1, 32'h3008, 0, 0, 0, 0, 32'h0,        0, 32'h0,    0, 32'h0,        4, 1, 3);
        tbl[15] = v("redir_wait",   1, 32'h3008, 0, 1, 0, 0, 32'h0,        0, 32'h0,    0, 32'h0,        4, 0, 3);
        tbl[16] = v("drain",        1, 32'h4180, 0, 0, 0, 0, 32'h0,        0, 32'h0,    0, 32'h0,        4, 1, 3);
        tbl[17] = v("drain_ack",    1, 32'h4180, 0, 0, 0, 1, 32'hDEADBEEF, 0, 32'h0,    0, 32'h0,        4, 1, 3);
        tbl[18] = v("req_new_pc",   1, 32'h4180, 0, 0, 0, 0, 32'h0,        1, 32'h4180, 0, 32'h0,        4, 1, 3);
        tbl[19] = v("wait_ack3",    1, 32'h4180, 0, 0, 0, 1, 32'h00000013, 0, 32'h0,    0, 32'h0,        4, 1, 3);
        tbl[20] = v("redir_full",   1, 32'h4180, 0, 1, 0, 0, 32'h0,        0, 32'h0,    0, 32'h00000013, 0, 0, 3);
        tbl[21] = v("redir_idle",   1, 32'h4184, 0, 1, 0, 0, 32'h0,        0, 32'h0,    0, 32'h00000013, 0, 0, 3);
        tbl[22] = v("req4",         1, 32'h4184, 0, 0, 0, 0, 32'h0,        1, 32'h4184, 0, 32'h00000013, 0, 1, 3);
        tbl[23] = v("redir_wait2",  1, 32'h4190, 0, 1, 0, 0, 32'h0,        0, 32'h0,    0, 32'h00000013, 0, 0, 3);
        tbl[24] = v("redir_drain",  1, 32'h4190, 0, 1, 0, 1, 32'hDEADBEEF, 0, 32'h0,    0, 32'h00000013, 0, 0, 3);
        tbl[25] = v("drain_ack2",   1, 32'h4190, 0, 0, 0, 1, 32'hDEADBEEF, 0, 32'h0,    0, 32'h00000013, 0, 1, 3);
        tbl[26] = v("req5",         1, 32'h4190, 0, 0, 0, 0, 32'h0,        1, 32'h4190, 0, 32'h00000013, 0, 1, 3);

        for (int i = 0; i < 27; i++) apply(tbl[i]);

        // Timeout: 16 WAIT cycles without acknowledge, then a bus-error fetch.
        for (int i = 0; i < 16; i++)
            apply(v($sformatf("timeout_wait%0d", i), 1, 32'h4190, 0, 0, 0, 0, 32'h0,
                    0, 32'h0, 0, 32'h13, 0, 1, 3));
        apply(v("timeout_full", 1, 32'h4190, 0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h0, 6, 0, 3));
        apply(v("req6",         1, 32'h41A0, 0, 0, 0, 0, 32'h0, 1, 32'h41A0, 0, 32'h0, 6, 1, 4));
        apply(v("wait6",        1, 32'h41A0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 6, 1, 4));

        // Reset in the middle of a request, with a stray acknowledge around release.
        apply(v("reset_mid",    0, 32'h41A0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1, 0));
        apply(v("reset_held",   0, 32'h41A0, 0, 0, 0, 1, 32'h77777777, 0, 32'h0, 0, 32'h0, 0, 1, 0));
        apply(v("rel_req",      1, 32'h5000, 0, 0, 0, 1, 32'h77777777, 1, 32'h5000, 0, 32'h0, 0, 1, 0));
        apply(v("rel_wait",     1, 32'h5000, 0, 0, 0, 1, 32'h11111111, 0, 32'h0, 0, 32'h0, 0, 1, 0));
        apply(v("rel_full",     1, 32'h5000, 0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h11111111, 0, 0, 0));
        apply(v("rel_next",     1, 32'h5004, 0, 0, 0, 0, 32'h0, 1, 32'h5004, 0, 32'h11111111, 0, 1, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
